// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl
//  Description : Multiply/divide unit controller for a MIPS-style pipeline.
//                Computes mult/multu/div/divu results at issue, holds them in
//                pending registers for a fixed latency, then commits them to
//                the architectural HI/LO registers. Also handles mthi/mtlo,
//                mfhi/mflo and the pipeline stall request.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDUC_i_Valid,
    input  logic [3:0]  MDUC_i_Op,
    input  logic [31:0] MDUC_i_A,
    input  logic [31:0] MDUC_i_B,
    input  logic        MDUC_i_Flush,
    output logic        MDUC_o_Busy,
    output logic        MDUC_o_Stall,
    output logic [31:0] MDUC_o_Rdata,
    output logic [31:0] MDUC_o_Hi,
    output logic [31:0] MDUC_o_Lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [3:0] MUL_LAT  = 4'd5;
    localparam logic [3:0] DIV_LAT  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;
    logic [31:0] phi_q,   phi_d;
    logic [31:0] plo_q,   plo_d;

    logic        w_is_mdu;
    logic        w_is_any;
    logic        w_busy;
    logic        w_stall;
    logic        w_issue;
    logic        w_wr_ok;
    logic        w_is_mul;

    logic [31:0] w_divisor;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_quot_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_quot_u;
    logic [31:0] w_rem_u;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    // Decode and pipeline handshake
    assign w_is_mdu = MDUC_i_Valid && (MDUC_i_Op >= OP_MULT) && (MDUC_i_Op <= OP_DIVU);
    assign w_is_any = MDUC_i_Valid && (MDUC_i_Op >= OP_MULT) && (MDUC_i_Op <= OP_MFLO);
    assign w_is_mul = (MDUC_i_Op == OP_MULT) || (MDUC_i_Op == OP_MULTU);
    assign w_busy   = (state_q != S_IDLE);
    assign w_stall  = w_is_any && w_busy;
    assign w_issue  = !w_busy && w_is_mdu && !MDUC_i_Flush;
    assign w_wr_ok  = MDUC_i_Valid && !w_stall && !MDUC_i_Flush;

    // Arithmetic datapath; a zero divisor is replaced by 1 so the divider
    // never sees 0 -- the result is discarded in that case anyway.
    assign w_divisor = (MDUC_i_B == 32'd0) ? 32'd1 : MDUC_i_B;
    assign w_prod_s  = $signed({{32{MDUC_i_A[31]}}, MDUC_i_A}) *
                       $signed({{32{MDUC_i_B[31]}}, MDUC_i_B});
    assign w_prod_u  = {32'd0, MDUC_i_A} * {32'd0, MDUC_i_B};
    assign w_quot_s  = $signed(MDUC_i_A) / $signed(w_divisor);
    assign w_rem_s   = $signed(MDUC_i_A) % $signed(w_divisor);
    assign w_quot_u  = MDUC_i_A / w_divisor;
    assign w_rem_u   = MDUC_i_A % w_divisor;

    // Select the result to park in the pending registers. Division by zero
    // parks the current HI/LO so completion leaves them unchanged; nothing
    // else can write HI/LO while the unit is busy.
    always_comb begin
        w_res_hi = hi_q;
        w_res_lo = lo_q;
        case (MDUC_i_Op)
            OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            OP_DIV: begin
                if (MDUC_i_B != 32'd0) begin
                    w_res_hi = w_rem_s;
                    w_res_lo = w_quot_s;
                end
            end
            OP_DIVU: begin
                if (MDUC_i_B != 32'd0) begin
                    w_res_hi = w_rem_u;
                    w_res_lo = w_quot_u;
                end
            end
            default: begin
                w_res_hi = hi_q;
                w_res_lo = lo_q;
            end
        endcase
    end

    // Next-state logic: issue, latency countdown, commit, and HI/LO moves
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        case (state_q)
            S_IDLE: begin
                if (w_issue) begin
                    phi_d   = w_res_hi;
                    plo_d   = w_res_lo;
                    cnt_d   = w_is_mul ? MUL_LAT : DIV_LAT;
                    state_d = w_is_mul ? S_MUL : S_DIV;
                end else if (w_wr_ok && (MDUC_i_Op == OP_MTHI)) begin
                    hi_d = MDUC_i_A;
                end else if (w_wr_ok && (MDUC_i_Op == OP_MTLO)) begin
                    lo_d = MDUC_i_A;
                end
            end
            S_MUL, S_DIV: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and data registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
        end
    end

    // Read port for mfhi/mflo
    always_comb begin
        MDUC_o_Rdata = 32'd0;
        if (MDUC_i_Op == OP_MFHI) begin
            MDUC_o_Rdata = hi_q;
        end else if (MDUC_i_Op == OP_MFLO) begin
            MDUC_o_Rdata = lo_q;
        end
    end

    assign MDUC_o_Busy  = w_busy;
    assign MDUC_o_Stall = w_stall;
    assign MDUC_o_Hi    = hi_q;
    assign MDUC_o_Lo    = lo_q;

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset; asserting it (0) clears all state immediately, independent of clk.
REQ-003 MDUC_i_Valid  in  1  E-stage instruction valid.
REQ-004 MDUC_i_Op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
REQ-005 MDUC_i_A, MDUC_i_B  in  32 each  rs / rt operands.
REQ-006 MDUC_i_Flush  in  1  exception/interrupt flush; suppresses any issue or write in the same cycle.
REQ-007 MDUC_o_Busy  out  1  multi-cycle operation in flight.
REQ-008 MDUC_o_Stall  out  1  combinational stall request to the pipeline.
REQ-009 MDUC_o_Rdata  out  32  combinational HI (op 7) or LO (op 8), else 0.
REQ-010 MDUC_o_Hi, MDUC_o_Lo  out  32 each  architectural HI/LO registers.

Function
REQ-011 FSM states IDLE, MUL, DIV; 4-bit down-counter; pending HI/LO registers.
REQ-012 Issue condition: state IDLE, Valid=1, Op in 1-4, Flush=0; at that edge, the block latches the result into the pending registers, loads the counter with L (5 for mult/multu, 10 for div/divu), and enters MUL or DIV.
REQ-013 Busy=1 exactly during the L cycles following the issue edge; Busy=0 in IDLE, including the issue cycle itself.
REQ-014 Counter decrements each busy cycle; at the L-th edge after issue, HI/LO take the pending values, the FSM returns to IDLE and Busy falls.
REQ-015 mult: {HI,LO} = signed 64-bit A*B. multu: unsigned 64-bit product.
REQ-016 div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend. divu: unsigned quotient/remainder.
REQ-017 Divide by zero: the operation issues and stays busy for 10 cycles; HI/LO are left unchanged at completion.
REQ-018 Stall = Valid & Op in 1-8 & (state != IDLE); ops 0 and 9-15 never stall.
REQ-019 A stalled op has no effect; a new issue is accepted in the first IDLE cycle.
REQ-020 mthi/mtlo: when not stalled and Flush=0, HI (or LO) <= A at the edge.
REQ-021 mfhi/mflo: when not stalled, Rdata = the current HI/LO value; in the cycle after completion it returns the newly written value.
REQ-022 Flush suppresses only same-cycle issue and mthi/mtlo writes; an in-flight operation always completes.
REQ-023 Flush=1 with Valid=1 and Op in 1-8 while busy: Stall still follows REQ-018.

Reset
REQ-024 On reset=0: state IDLE, counter 0, HI=LO=0, pending registers 0, Busy=0; Stall and Rdata depend only on the inputs and these reset values.
REQ-025 Reset asserted mid-operation aborts it; HI/LO stay 0, and the first post-reset issue behaves per REQ-012.

Verification
REQ-026 Scenario 1: mult with A=12345678, B=24691356 -> Busy high 5 cycles, then HI=0x0001153E and LO=0x1F186788.
REQ-027 Scenario 2: div with A=-12345678, B=126 -> Busy high 10 cycles, then LO=0xFFFE8143 (-97981) and HI=0xFFFFFFB8 (-72).
REQ-028 Scenario 3: mflo presented on the issue cycle +1 after a mult -> Stall=1 for 5 cycles, then Stall=0 and Rdata = the new LO.
REQ-029 Scenario 4: divu with B=0 while HI=0x11, LO=0x22 -> Busy 10 cycles, then HI=0x11 and LO=0x22 are unchanged.
REQ-030 Scenario 5: mthi with A=0xDEADBEEF and Flush=1 -> HI unchanged; the same op with Flush=0 -> HI=0xDEADBEEF next cycle.
REQ-031 Scenario 6: reset=0 pulsed at busy cycle 3 of a div -> Busy=0 and HI=LO=0 immediately without a clock edge; then a mult 3*4 -> LO=12 and HI=0 after 5 cycles.
